// File: rtl/udp_transmit_pkg.sv
// Shared types and IPv4 field helpers for the UDP transmit handler.
package udp_transmit_pkg;

    typedef enum logic [1:0] {
        S_IDLE                = 2'd0,
        S_FIND_EMPTY_QUE_SLOT = 2'd1,
        S_PUSH_DATA           = 2'd2
    } state_type;

    localparam int unsigned IPV4_FLAG_MF_BIT  = 13;
    localparam int unsigned IPV4_OFFSET_WIDTH = 13;
    localparam int unsigned IPV4_FIELD_WIDTH  = 16;
    localparam int unsigned BYTE_COUNT_WIDTH  = 16;

    // Flags word: reserved and DF bits stay 0, MF at bit 13, offset in [12:0].
    function automatic logic [IPV4_FIELD_WIDTH-1:0] ipv4_flags_word(
        input logic                         more_fragments,
        input logic [IPV4_OFFSET_WIDTH-1:0] offset
    );
        logic [IPV4_FIELD_WIDTH-1:0] word;
        word                                = '0;
        word[IPV4_FLAG_MF_BIT]              = more_fragments;
        word[IPV4_OFFSET_WIDTH-1:0]         = offset;
        return word;
    endfunction

endpackage

// File: rtl/udp_transmit_handler_cycle_timer.sv
// Reloadable down-counter flagging expiry at zero; only built when
// UDP_TRANSMIT_TIMEOUT_EN is defined.
`ifdef UDP_TRANSMIT_TIMEOUT_EN
module cycle_timer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_reload,
    input  logic [WIDTH-1:0] i_limit,
    output logic             o_expired
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_reload) begin
            r_count <= i_limit;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_expired = (r_count == '0);

endmodule
`endif

// File: rtl/udp_transmit_handler.sv
// Round-robin UDP datagram source drain that splits datagrams into IPv4
// fragments and pushes them into free transmit-queue slots.
// Optional idle timeout: define UDP_TRANSMIT_TIMEOUT_EN.
module udp_transmit_handler
    import udp_transmit_pkg::*;
#(
    parameter int unsigned TRANSMIT_SLOTS         = 4,
    parameter int unsigned TRANSMIT_QUE_SLOTS     = 4,
    parameter int unsigned FRAGMENT_PAYLOAD_BYTES = 1480,
    parameter logic [15:0] TIMEOUT_LIMIT          = 16'h0010
) (
    input  logic                                 clock,
    input  logic                                 reset_n,
    input  logic [TRANSMIT_SLOTS-1:0]            enable,
    input  logic [TRANSMIT_SLOTS-1:0][7:0]       data,
    input  logic [TRANSMIT_SLOTS-1:0]            data_enable,
    input  logic [TRANSMIT_SLOTS-1:0]            data_last,
    input  logic [TRANSMIT_QUE_SLOTS-1:0]        que_slot_empty,
    input  logic [TRANSMIT_QUE_SLOTS-1:0]        que_ready,
    output logic [TRANSMIT_SLOTS-1:0]            data_ready,
    output logic [7:0]                           push_data,
    output logic [TRANSMIT_QUE_SLOTS-1:0]        push_data_valid,
    output logic [TRANSMIT_QUE_SLOTS-1:0]        push_data_last,
    output logic                                 header_valid,
    output logic [IPV4_FIELD_WIDTH-1:0]          ipv4_identification,
    output logic [IPV4_FIELD_WIDTH-1:0]          ipv4_flags,
    output logic                                 busy,
    output logic                                 abort
);

    localparam int unsigned SRC_W = (TRANSMIT_SLOTS > 1) ? $clog2(TRANSMIT_SLOTS) : 1;
    localparam int unsigned QUE_W = (TRANSMIT_QUE_SLOTS > 1) ? $clog2(TRANSMIT_QUE_SLOTS) : 1;
    localparam int unsigned OFS_W = IPV4_OFFSET_WIDTH;
    localparam int unsigned ID_W  = IPV4_FIELD_WIDTH;
    localparam int unsigned CNT_W = BYTE_COUNT_WIDTH;

    // Control state
    state_type              r_state;
    state_type              w_state_next;
    logic [SRC_W-1:0]       r_src_sel;
    logic [SRC_W-1:0]       w_src_sel_next;
    logic [QUE_W-1:0]       r_que_sel;
    logic [QUE_W-1:0]       w_que_sel_next;
    logic [ID_W-1:0]        r_id;
    logic [ID_W-1:0]        w_id_next;
    logic [OFS_W-1:0]       r_offset;
    logic [OFS_W-1:0]       w_offset_next;
    logic [CNT_W-1:0]       r_byte_count;
    logic [CNT_W-1:0]       w_byte_count_next;

    // Registered outputs and their next values
    logic [7:0]                    r_push_data;
    logic [7:0]                    w_push_data_next;
    logic [TRANSMIT_QUE_SLOTS-1:0] r_push_data_valid;
    logic [TRANSMIT_QUE_SLOTS-1:0] w_push_data_valid_next;
    logic [TRANSMIT_QUE_SLOTS-1:0] r_push_data_last;
    logic [TRANSMIT_QUE_SLOTS-1:0] w_push_data_last_next;
    logic                          r_header_valid;
    logic                          w_header_valid_next;
    logic [ID_W-1:0]               r_ipv4_identification;
    logic [ID_W-1:0]               w_ipv4_identification_next;
    logic [ID_W-1:0]               r_ipv4_flags;
    logic [ID_W-1:0]               w_ipv4_flags_next;
    logic                          r_abort;
    logic                          w_abort_next;

    logic                          w_pop;
    logic                          w_boundary;
    logic                          w_close_last;
    logic                          w_close_frag;
    logic                          w_timeout;
    logic [SRC_W-1:0]              w_src_sel_inc;
    logic [QUE_W-1:0]              w_que_sel_inc;
    logic [TRANSMIT_QUE_SLOTS-1:0] w_que_onehot;
    logic [TRANSMIT_SLOTS-1:0]     w_src_onehot;

    assign w_src_sel_inc = (r_src_sel == SRC_W'(TRANSMIT_SLOTS - 1)) ? '0 : r_src_sel + SRC_W'(1);
    assign w_que_sel_inc = (r_que_sel == QUE_W'(TRANSMIT_QUE_SLOTS - 1)) ? '0 : r_que_sel + QUE_W'(1);
    assign w_que_onehot  = TRANSMIT_QUE_SLOTS'(1) << r_que_sel;
    assign w_src_onehot  = TRANSMIT_SLOTS'(1) << r_src_sel;

    // A byte moves only when the source has one and the chosen queue slot can take it.
    assign w_pop        = (r_state == S_PUSH_DATA) && data_enable[r_src_sel] && que_ready[r_que_sel];
    assign w_boundary   = (r_byte_count == CNT_W'(FRAGMENT_PAYLOAD_BYTES - 1));
    assign w_close_last = w_pop && data_last[r_src_sel];
    assign w_close_frag = w_pop && !data_last[r_src_sel] && w_boundary;

`ifdef UDP_TRANSMIT_TIMEOUT_EN
    logic w_timer_reload;
    logic w_timer_expired;

    assign w_timer_reload = w_pop ||
                            ((r_state != S_PUSH_DATA) && (w_state_next == S_PUSH_DATA));

    cycle_timer #(
        .WIDTH (16)
    ) timeout_cycle_timer (
        .i_clk     (clock),
        .i_rst_n   (reset_n),
        .i_reload  (w_timer_reload),
        .i_limit   (TIMEOUT_LIMIT),
        .o_expired (w_timer_expired)
    );

    assign w_timeout = (r_state == S_PUSH_DATA) && !w_pop && w_timer_expired;
`else
    logic w_unused_timeout_limit;

    assign w_unused_timeout_limit = ^TIMEOUT_LIMIT;
    assign w_timeout              = 1'b0;
`endif

    // State and datapath registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_src_sel    <= '0;
            r_que_sel    <= '0;
            r_id         <= '0;
            r_offset     <= '0;
            r_byte_count <= '0;
        end else begin
            r_state      <= w_state_next;
            r_src_sel    <= w_src_sel_next;
            r_que_sel    <= w_que_sel_next;
            r_id         <= w_id_next;
            r_offset     <= w_offset_next;
            r_byte_count <= w_byte_count_next;
        end
    end

    // Next-state and pointer logic
    always_comb begin
        w_state_next      = r_state;
        w_src_sel_next    = r_src_sel;
        w_que_sel_next    = r_que_sel;
        w_id_next         = r_id;
        w_offset_next     = r_offset;
        w_byte_count_next = r_byte_count;

        case (r_state)
            S_IDLE: begin
                if (enable[r_src_sel]) begin
                    w_state_next   = S_FIND_EMPTY_QUE_SLOT;
                    w_que_sel_next = '0;
                    w_offset_next  = '0;
                end else begin
                    w_src_sel_next = w_src_sel_inc;
                end
            end
            S_FIND_EMPTY_QUE_SLOT: begin
                if (que_slot_empty[r_que_sel]) begin
                    w_state_next      = S_PUSH_DATA;
                    w_byte_count_next = '0;
                end else begin
                    w_que_sel_next = w_que_sel_inc;
                end
            end
            S_PUSH_DATA: begin
                // data_last wins over the payload boundary, so no empty trailing fragment.
                if (w_close_last || w_timeout) begin
                    w_state_next   = S_IDLE;
                    w_id_next      = r_id + ID_W'(1);
                    w_src_sel_next = w_src_sel_inc;
                end else if (w_close_frag) begin
                    w_state_next   = S_FIND_EMPTY_QUE_SLOT;
                    w_que_sel_next = '0;
                    w_offset_next  = r_offset + OFS_W'(FRAGMENT_PAYLOAD_BYTES / 8);
                end else if (w_pop) begin
                    w_byte_count_next = r_byte_count + CNT_W'(1);
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Output next values; header fields hold between closing fragments
    always_comb begin
        w_push_data_next           = r_push_data;
        w_push_data_valid_next     = '0;
        w_push_data_last_next      = '0;
        w_header_valid_next        = 1'b0;
        w_ipv4_identification_next = r_ipv4_identification;
        w_ipv4_flags_next          = r_ipv4_flags;
        w_abort_next               = 1'b0;

        if (w_pop) begin
            w_push_data_next       = data[r_src_sel];
            w_push_data_valid_next = w_que_onehot;
        end
        if (w_close_last || w_close_frag) begin
            w_push_data_last_next      = w_que_onehot;
            w_header_valid_next        = 1'b1;
            w_ipv4_identification_next = r_id;
            w_ipv4_flags_next          = ipv4_flags_word(w_close_frag, r_offset);
        end
        if (w_timeout) begin
            w_push_data_last_next      = w_que_onehot;
            w_header_valid_next        = 1'b1;
            w_ipv4_identification_next = r_id;
            w_ipv4_flags_next          = ipv4_flags_word(1'b0, r_offset);
            w_abort_next               = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_push_data           <= '0;
            r_push_data_valid     <= '0;
            r_push_data_last      <= '0;
            r_header_valid        <= 1'b0;
            r_ipv4_identification <= '0;
            r_ipv4_flags          <= '0;
            r_abort               <= 1'b0;
        end else begin
            r_push_data           <= w_push_data_next;
            r_push_data_valid     <= w_push_data_valid_next;
            r_push_data_last      <= w_push_data_last_next;
            r_header_valid        <= w_header_valid_next;
            r_ipv4_identification <= w_ipv4_identification_next;
            r_ipv4_flags          <= w_ipv4_flags_next;
            r_abort               <= w_abort_next;
        end
    end

    assign data_ready          = w_pop ? w_src_onehot : '0;
    assign push_data           = r_push_data;
    assign push_data_valid     = r_push_data_valid;
    assign push_data_last      = r_push_data_last;
    assign header_valid        = r_header_valid;
    assign ipv4_identification = r_ipv4_identification;
    assign ipv4_flags          = r_ipv4_flags;
    assign busy                = (r_state != S_IDLE);
    assign abort               = r_abort;

endmodule
